// File: rtl/rgmii_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_tx_encoder
// Description : GMII transmit byte stream to RGMII DDR half-cycle words.
//               Produces per-cycle (d1, d2) words for the data/ctl DDR
//               output stage and a separate TXC pattern for the clock stage.
//               1000 Mb/s: one byte per cycle, TXC = (1,0).
//               100/10 Mb/s: each nibble is held for P = 5 / 50 cycles, the
//               MAC is throttled with gmii_clk_en, and TXC rises mid-nibble
//               so the data is centred on the TXC rising edge.
// Ports       : clk          125 MHz transmit clock
//               rst_n        asynchronous active-low reset
//               speed        2'b1x = 1000, 2'b01 = 100, 2'b00 = 10
//               gmii_txd     transmit byte
//               gmii_tx_en   transmit enable
//               gmii_tx_er   transmit error
//               gmii_clk_en  MAC sampling strobe (registered state only)
//               txd_d1/d2    data nibble, first/second half-cycle
//               ctl_d1/d2    TX_CTL, first/second half-cycle
//               txc_d1/d2    TXC level, first/second half-cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rgmii_tx_encoder #(
    parameter int CNT_WIDTH = 6     // must be able to hold 49
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_clk_en,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       ctl_d1,
    output logic       ctl_d2,
    output logic       txc_d1,
    output logic       txc_d2
);

    typedef enum logic [1:0] {
        M_10   = 2'd0,
        M_100  = 2'd1,
        M_1000 = 2'd2
    } mode_t;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t C_ONE = cnt_t'(1);

    // Last counter value (P-1) for a given mode.
    function automatic cnt_t last_cnt(input mode_t m);
        case (m)
            M_100:   last_cnt = cnt_t'(4);
            M_10:    last_cnt = cnt_t'(49);
            default: last_cnt = cnt_t'(0);
        endcase
    endfunction

    // Registered state
    mode_t      mode;
    logic       phase;          // 0 = low nibble on the wire, 1 = high nibble
    cnt_t       cnt;
    logic [3:0] hi_nib;         // high nibble of the byte being sent

    // Next-state values
    mode_t      mode_n;
    logic       phase_n;
    cnt_t       cnt_n;
    logic [3:0] hi_nib_n;
    logic [3:0] txd1_n, txd2_n;
    logic       ctl1_n, ctl2_n, txc1_n, txc2_n;

    mode_t      speed_mode;
    logic       at_last;

    always_comb begin
        if (speed[1])      speed_mode = M_1000;
        else if (speed[0]) speed_mode = M_100;
        else               speed_mode = M_10;
    end

    assign at_last     = (cnt == last_cnt(mode));
    assign gmii_clk_en = (mode == M_1000) || (phase && at_last);

    always_comb begin
        mode_n   = mode;
        phase_n  = phase;
        cnt_n    = cnt;
        hi_nib_n = hi_nib;
        txd1_n   = txd_d1;
        txd2_n   = txd_d2;
        ctl1_n   = ctl_d1;
        ctl2_n   = ctl_d2;
        txc1_n   = txc_d1;
        txc2_n   = txc_d2;

        if (speed_mode != mode) begin
            // Speed change: abandon the byte in flight, park the state so the
            // MAC is strobed on the very next cycle, and idle the wire once.
            mode_n   = speed_mode;
            phase_n  = 1'b1;
            cnt_n    = last_cnt(speed_mode);
            hi_nib_n = 4'h0;
            txd1_n   = 4'h0;
            txd2_n   = 4'h0;
            ctl1_n   = 1'b0;
            ctl2_n   = 1'b0;
            txc1_n   = 1'b0;
            txc2_n   = 1'b0;
        end else if (mode == M_1000) begin
            phase_n = 1'b1;
            cnt_n   = '0;
            txd1_n  = gmii_txd[3:0];
            txd2_n  = gmii_txd[7:4];
            ctl1_n  = gmii_tx_en;
            ctl2_n  = gmii_tx_en ^ gmii_tx_er;
            txc1_n  = 1'b1;
            txc2_n  = 1'b0;
        end else begin
            if (at_last) begin
                cnt_n   = '0;
                phase_n = ~phase;
            end else begin
                cnt_n   = cnt + C_ONE;
            end

            if (gmii_clk_en) begin
                hi_nib_n = gmii_txd[7:4];
                txd1_n   = gmii_txd[3:0];
                txd2_n   = gmii_txd[3:0];
                ctl1_n   = gmii_tx_en;
                ctl2_n   = gmii_tx_en ^ gmii_tx_er;
            end else if (!phase && at_last) begin
                txd1_n   = hi_nib;
                txd2_n   = hi_nib;
            end

            // TXC is indexed by the counter value of the upcoming cycle; the
            // 100 Mb/s pattern rises in the middle of cycle 2 of 5.
            if (mode == M_100) begin
                txc1_n = (cnt_n > cnt_t'(2));
                txc2_n = (cnt_n >= cnt_t'(2));
            end else begin
                txc1_n = (cnt_n >= cnt_t'(25));
                txc2_n = (cnt_n >= cnt_t'(25));
            end
        end
    end

    // Reset parks the block in 1000 mode (P-1 = 0, phase 1), which strobes
    // the MAC in the first cycle; another speed is entered through the
    // speed-change path on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= M_1000;
            phase  <= 1'b1;
            cnt    <= '0;
            hi_nib <= 4'h0;
            txd_d1 <= 4'h0;
            txd_d2 <= 4'h0;
            ctl_d1 <= 1'b0;
            ctl_d2 <= 1'b0;
            txc_d1 <= 1'b0;
            txc_d2 <= 1'b0;
        end else begin
            mode   <= mode_n;
            phase  <= phase_n;
            cnt    <= cnt_n;
            hi_nib <= hi_nib_n;
            txd_d1 <= txd1_n;
            txd_d2 <= txd2_n;
            ctl_d1 <= ctl1_n;
            ctl_d2 <= ctl2_n;
            txc_d1 <= txc1_n;
            txc_d2 <= txc2_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgmii_tx_encoder
// Description : Directed, table-driven bench for rgmii_tx_encoder covering
//               1000 vectors, 100/10 nibble stretching, speed changes and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgmii_tx_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       gmii_clk_en;
    logic [3:0] txd_d1, txd_d2;
    logic       ctl_d1, ctl_d2, txc_d1, txc_d2;

    int errors = 0;
    int checks = 0;

    rgmii_tx_encoder #(.CNT_WIDTH(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .speed       (speed),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .gmii_clk_en (gmii_clk_en),
        .txd_d1      (txd_d1),
        .txd_d2      (txd_d2),
        .ctl_d1      (ctl_d1),
        .ctl_d2      (ctl_d2),
        .txc_d1      (txc_d1),
        .txc_d2      (txc_d2)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] txd;
        logic       en;
        logic       er;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [1:0] ctl;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec TXC table per nibble cycle.
    function automatic logic [1:0] txc_pat(input int p, input int c);
        if (p == 5) begin
            if (c < 2)       return 2'b00;
            else if (c == 2) return 2'b01;
            else             return 2'b11;
        end else begin
            return (c < 25) ? 2'b00 : 2'b11;
        end
    endfunction

    // Called in a cycle where clk_en=1 and byte b is presented; walks the
    // 2P cycles of that byte and presents nb/nen in the final one.
    task automatic slow_byte(input int p, input logic [7:0] b, input logic [1:0] ectl,
                             input logic [7:0] nb, input logic nen);
        logic [3:0] nib;
        for (int j = 0; j < 2 * p; j++) begin
            tick();
            nib = (j < p) ? b[3:0] : b[7:4];
            chk("slow_txd", {txd_d1, txd_d2}, {nib, nib});
            chk("slow_ctl", {ctl_d1, ctl_d2}, ectl);
            chk("slow_txc", {txc_d1, txc_d2}, txc_pat(p, j % p));
            chk("slow_clk_en", gmii_clk_en, (j == 2 * p - 1));
            if (j == 2 * p - 1) begin
                gmii_txd   = nb;
                gmii_tx_en = nen;
            end
        end
    endtask

    // Cycles from the current cycle to the next clk_en pulse (bounded).
    task automatic gap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!gmii_clk_en && n < 200);
    endtask

    int g;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 4'h5, 4'hA, 2'b11};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b10};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 2'b01};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 4'hC, 4'h3, 2'b00};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 4'hF, 4'hF, 2'b11};

        rst_n      = 1'b0;
        speed      = 2'b10;
        gmii_txd   = 8'hA5;
        gmii_tx_en = 1'b1;
        gmii_tx_er = 1'b0;
        repeat (2) tick();
        chk("rst_outputs", {txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2}, 12'h000);
        rst_n = 1'b1;
        chk("rst_clk_en", gmii_clk_en, 1'b1);

        // 1000 mode table
        for (int i = 0; i < 5; i++) begin
            gmii_txd   = vecs[i].txd;
            gmii_tx_en = vecs[i].en;
            gmii_tx_er = vecs[i].er;
            tick();
            chk("g_txd", {txd_d1, txd_d2}, {vecs[i].d1, vecs[i].d2});
            chk("g_ctl", {ctl_d1, ctl_d2}, vecs[i].ctl);
            chk("g_txc", {txc_d1, txc_d2}, 2'b10);
            chk("g_clk_en", gmii_clk_en, 1'b1);
        end

        // 1000 -> 100, then bytes 0x3C, 0x71
        gmii_tx_en = 1'b1;
        gmii_tx_er = 1'b0;
        speed = 2'b01;
        tick();
        chk("chg100_ctl_txc", {ctl_d1, ctl_d2, txc_d1, txc_d2}, 4'h0);
        chk("chg100_clk_en", gmii_clk_en, 1'b1);
        gmii_txd = 8'h3C;
        slow_byte(5, 8'h3C, 2'b11, 8'h71, 1'b1);
        slow_byte(5, 8'h71, 2'b11, 8'hE2, 1'b1);

        // 100 -> 10, byte 0xE2
        speed = 2'b00;
        tick();
        chk("chg10_ctl_txc", {ctl_d1, ctl_d2, txc_d1, txc_d2}, 4'h0);
        chk("chg10_clk_en", gmii_clk_en, 1'b1);
        gmii_txd = 8'hE2;
        slow_byte(50, 8'hE2, 2'b11, 8'h55, 1'b1);

        // 10 -> 1000 at cnt=17, phase 0
        repeat (18) tick();
        chk("pre_chg_txd", {txd_d1, txd_d2}, 8'h55);
        chk("pre_chg_txc", {txc_d1, txc_d2}, 2'b00);
        speed    = 2'b11;
        gmii_txd = 8'h96;
        tick();
        chk("chg1000_ctl_txc", {ctl_d1, ctl_d2, txc_d1, txc_d2}, 4'h0);
        chk("chg1000_clk_en", gmii_clk_en, 1'b1);
        tick();
        chk("post1000_txd", {txd_d1, txd_d2}, 8'h69);
        chk("post1000_ctl", {ctl_d1, ctl_d2}, 2'b11);
        chk("post1000_txc", {txc_d1, txc_d2}, 2'b10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post1000_clk_en", gmii_clk_en, 1'b1);
        end

        // 1000 -> 100 cadence
        speed = 2'b01;
        tick();
        chk("chg100b_clk_en", gmii_clk_en, 1'b1);
        chk("chg100b_ctl", {ctl_d1, ctl_d2}, 2'b00);
        gap(g);
        chk("cadence100_a", g, 10);
        gap(g);
        chk("cadence100_b", g, 10);

        // Asynchronous reset mid-nibble in 100 mode
        repeat (3) tick();
        chk("pre_rst_ctl", {ctl_d1, ctl_d2}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2}, 12'h000);
        tick();
        rst_n = 1'b1;
        chk("rst2_clk_en", gmii_clk_en, 1'b1);
        gap(g);
        gap(g);
        chk("cadence_rst_a", g, 10);
        gap(g);
        chk("cadence_rst_b", g, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgmii_tx_encoder.md
Name: rgmii_tx_encoder

Overview:
Converts a GMII-style transmit byte stream (txd/tx_en/tx_er) into the per-cycle DDR half-cycle words consumed by the source-synchronous DDR output stage: data nibbles, TX_CTL, and TXC clock pattern. It runs in the 125 MHz transmit domain and supports 1000/100/10 Mb/s. At 100 and 10 it stretches each nibble with an internal divider and throttles the MAC with a clock enable. Its outputs drive two DDR output stages directly: data plus ctl (WIDTH 5), and a separate clock stage fed with the txc pattern.

Parameters:
CNT_WIDTH, 6, width of the nibble-period counter; must hold 49 (values below 6 are illegal).

Ports:
clk  input  1  125 MHz transmit clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset, synchronously deasserted externally
speed  input  2  2'b10 or 2'b11 = 1000, 2'b01 = 100, 2'b00 = 10; quasi-static
gmii_txd  input  8  transmit byte
gmii_tx_en  input  1  transmit enable
gmii_tx_er  input  1  transmit error
gmii_clk_en  output  1  inputs are sampled on the rising edge ending any cycle where this is 1
txd_d1  output  4  data nibble for the first (rising) half-cycle
txd_d2  output  4  data nibble for the second half-cycle
ctl_d1  output  1  TX_CTL for the first half-cycle
ctl_d2  output  1  TX_CTL for the second half-cycle
txc_d1  output  1  TXC level for the first half-cycle
txc_d2  output  1  TXC level for the second half-cycle

Behaviour:
- Reset (async, rst_n=0): all d1/d2 outputs = 0. State is phase=1, cnt=P-1, so gmii_clk_en=1 in the first cycle after release.
- Period P per nibble: 1000 = 1 (no divider), 100 = 5, 10 = 50.
- gmii_clk_en is decoded combinationally from registered state only. Value: 1 when in 1000 mode, otherwise (phase==1 && cnt==P-1). It has no combinational path from the data inputs.
- 1000 mode, registered with 1-cycle latency:
  - txd_d1 = txd[3:0], txd_d2 = txd[7:4]
  - ctl_d1 = tx_en, ctl_d2 = tx_en ^ tx_er
  - txc_d1 = 1, txc_d2 = 0
- 10/100 mode state: cnt runs 0..P-1. Wrap at P-1 toggles phase (0 = low nibble, 1 = high nibble).
- At a sampling edge (gmii_clk_en=1):
  - byte_reg <= txd, en_reg <= tx_en, er_reg <= tx_er
  - txd_d1 = txd_d2 <= txd[3:0] for the next P cycles
  - then txd_d1 = txd_d2 <= byte_reg[7:4] for the following P cycles
  - ctl_d1 <= tx_en and ctl_d2 <= tx_en ^ tx_er, held for all 2P cycles
- Clock pattern is loaded in the same cycle as the data and indexed by the upcoming cnt. TXC rises mid-nibble, so data is centred on the rising edge.
  - 100: cnt 0,1 -> (0,0); cnt 2 -> (0,1); cnt 3,4 -> (1,1).
  - 10: cnt 0..24 -> (0,0); cnt 25..49 -> (1,1).
- Speed change: speed is registered. When the registered value differs from the current speed:
  - state is forced to phase=1, cnt=P_new-1, so gmii_clk_en=1 on the next cycle
  - any byte in progress is truncated
  - ctl outputs are forced to 0 for that one cycle
  - txc outputs are forced to 0 for that one cycle
  - no X, no counter overrun past P_new-1
- Reset mid-frame: outputs go to 0 immediately (asynchronously). Operation resumes as after power-up.
- Counter never exceeds 49; a 1000->10 change while cnt=0 is covered by the forced reload.

Test Plan:
- Reset release at 1000 with txd=0xA5, en=1, er=0: gmii_clk_en=1 every cycle. One cycle later txd_d1=0x5, txd_d2=0xA, ctl=(1,1), txc=(1,0).
- 1000 error: txd=0x00, en=1, er=1 -> ctl=(1,0). With en=0, er=1 (carrier extend) -> ctl=(0,1).
- 100 mode, bytes 0x3C then 0x71:
  - gmii_clk_en pulses exactly every 10 cycles
  - txd_d1=txd_d2=0xC for 5 cycles, then 0x3 for 5 cycles, then 0x1, then 0x7
  - txc sequence per nibble: (0,0),(0,0),(0,1),(1,1),(1,1)
- 10 mode, byte 0xE2: gmii_clk_en period 100 cycles. Nibble 0x2 held 50 cycles with txc low for 25 and high for 25, then 0xE held 50 cycles.
- Speed change 10->1000 at cnt=17, phase 0: exactly one cycle with ctl=0 and txc=0, then gmii_clk_en=1 continuously with 1000 behaviour. Also check 1000->100: first clk_en, then a 10-cycle cadence.
- Assert rst_n=0 mid-nibble in 100 mode: all outputs 0 in the same cycle, without waiting for a clock edge. After release, gmii_clk_en=1 in the first cycle and the normal cadence resumes.
